uart_timestamp_gen: RTL and testbench
=====================================

// Module: uart_timestamp_gen
// PURPOSE
//  - Free-running time-stamp generator feeding the UART core's acqurate/millisecond/second stamp inputs.
//  - Produces a coherent {second, millisecond, 100us} triple from the 40 MHz system clock.
//  - Also provides per-unit tick strobes, a software second-load, and a coherent snapshot register.
//  - Sits directly upstream of the UART core. All three stamp outputs change on the same clock edge.
// PARAMETERS
//  CLK_FREQ_HZ  40_000_000  system clock frequency in Hz
//  SUB_MS_DIV   10          acqurate-stamp units per millisecond (100 us resolution); must be <= 16
//  PRESC_DIV    CLK_FREQ_HZ/(1000*SUB_MS_DIV)  derived localparam: clocks per acqurate unit (4000 at default)
// PORTS
//  clk                  in   1   system clock
//  rst                  in   1   asynchronous, active-low reset
//  p_Enable_i           in   1   1 = time advances; 0 = prescaler and all counters hold
//  p_SecLoad_i          in   1   single-cycle pulse: load SecLoadVal_i into the second counter
//  SecLoadVal_i         in   32  second value to load
//  p_Snapshot_i         in   1   single-cycle pulse: capture the current stamp triple
//  acqurate_stamp_o     out  4   sub-ms count, 0..SUB_MS_DIV-1
//  millisecond_stamp_o  out  12  ms count, 0..999
//  second_stamp_o       out  32  seconds, wraps modulo 2^32
//  p_TickAcq_o          out  1   1-cycle pulse when acqurate_stamp_o advances
//  p_TickMs_o           out  1   1-cycle pulse when millisecond_stamp_o advances
//  p_TickSec_o          out  1   1-cycle pulse when second_stamp_o advances by counting (not by load)
//  SnapStamp_o          out  48  captured {second[31:0], ms[11:0], acq[3:0]}
//  p_SnapValid_o        out  1   1-cycle pulse, asserted with the new SnapStamp_o
// BEHAVIOUR
//  - Reset: all counters, stamp outputs, SnapStamp_o and all pulse outputs are 0.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - Prescaler counts 0..PRESC_DIV-1 while p_Enable_i=1.
//  - Edge with prescaler==PRESC_DIV-1: prescaler->0, acq+1, p_TickAcq_o=1 in the cycle the new value appears.
//  - Carry chain is resolved in the same edge:
//    - acq wraps SUB_MS_DIV-1->0 and ms+1 (p_TickMs_o=1).
//    - ms wraps 999->0 and sec+1 (p_TickSec_o=1).
//    - sec wraps 0xFFFFFFFF->0 silently.
//  - p_Enable_i=0: prescaler and counters frozen; tick outputs held 0. Counting resumes from the frozen prescaler value.
//  - p_SecLoad_i=1 (regardless of p_Enable_i), next edge:
//    - sec=SecLoadVal_i; ms=0, acq=0, prescaler=0.
//    - All tick outputs are 0 that cycle. Load wins over a coincident tick.
//  - p_Snapshot_i=1, next edge: SnapStamp_o = stamp outputs as they were during the request cycle; p_SnapValid_o=1.
//    - With a coincident load or tick, the pre-update values are captured.
//    - SnapStamp_o holds until the next snapshot.
//  - Back-to-back snapshot pulses are each honoured.
// CONFIGURATION
//  PPS_SYNC_EN defined: adds input pps_i (1 bit, asynchronous) and output p_PpsLost_o (1 bit, reset 0).
//    - pps_i passes through a 2-flop synchroniser; a rising edge is detected on the synchronised signal.
//    - On an edge: prescaler, ms and acq -> 0.
//      - If ms >= 500 before the edge, sec+1 and p_TickSec_o=1; otherwise sec is unchanged.
//    - p_SecLoad_i in the same cycle wins; the PPS edge is discarded.
//    - p_PpsLost_o is set when 1500 ms elapse with no edge; it clears on the next edge or on reset.
//  PPS_SYNC_EN undefined: pps_i and p_PpsLost_o do not exist; time base is the prescaler only.
// TESTING (bench uses CLK_FREQ_HZ=100_000, so PRESC_DIV=10)
//  1. Reset release, p_Enable_i=1 -> first p_TickAcq_o at clock 10; acq=1 there; ms tick after 100 clocks.
//  2. Force/run to sec=0xFFFFFFFF, ms=999, acq=9 plus one acq tick -> all stamps 0; TickAcq/Ms/Sec all 1 in the same cycle.
//  3. p_SecLoad_i with SecLoadVal_i=0x12345678 on a tick cycle -> sec=0x12345678, ms=0, acq=0, no tick pulses.
//  4. p_Snapshot_i coincident with an ms carry at ms=41, acq=9 -> SnapStamp_o shows ms=41, acq=9; p_SnapValid_o 1 cycle.
//  5. p_Enable_i low for 37 clocks mid-count -> stamps and prescaler frozen; next tick delayed exactly 37 clocks.
//  6. (PPS_SYNC_EN) pps_i rises at ms=700 -> sec+1, ms=0 three clocks later; no pps for 1500 ms -> p_PpsLost_o=1.

Source files
------------

// File: rtl/uart_timestamp_gen_if.sv
// ============================================================================
//  uart_timestamp_gen_if
//  Control/stamp bundle between the time-stamp generator and its host.
//  PPS_SYNC_EN adds the pps_i input and the p_PpsLost_o flag.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface uart_timestamp_gen_if;
   logic        p_Enable_i;
   logic        p_SecLoad_i;
   logic [31:0] SecLoadVal_i;
   logic        p_Snapshot_i;
   logic [3:0]  acqurate_stamp_o;
   logic [11:0] millisecond_stamp_o;
   logic [31:0] second_stamp_o;
   logic        p_TickAcq_o;
   logic        p_TickMs_o;
   logic        p_TickSec_o;
   logic [47:0] SnapStamp_o;
   logic        p_SnapValid_o;
`ifdef PPS_SYNC_EN
   logic        pps_i;
   logic        p_PpsLost_o;
`endif

   modport master (
`ifdef PPS_SYNC_EN
      output pps_i,
      input  p_PpsLost_o,
`endif
      output p_Enable_i, p_SecLoad_i, SecLoadVal_i, p_Snapshot_i,
      input  acqurate_stamp_o, millisecond_stamp_o, second_stamp_o,
      input  p_TickAcq_o, p_TickMs_o, p_TickSec_o, SnapStamp_o, p_SnapValid_o
   );

   modport slave (
`ifdef PPS_SYNC_EN
      input  pps_i,
      output p_PpsLost_o,
`endif
      input  p_Enable_i, p_SecLoad_i, SecLoadVal_i, p_Snapshot_i,
      output acqurate_stamp_o, millisecond_stamp_o, second_stamp_o,
      output p_TickAcq_o, p_TickMs_o, p_TickSec_o, SnapStamp_o, p_SnapValid_o
   );
endinterface

`default_nettype wire

// File: rtl/uart_timestamp_gen.sv
// ============================================================================
//  uart_timestamp_gen
//  Free-running {second, ms, sub-ms} stamp generator with tick strobes,
//  second load and coherent snapshot. Optional macro: PPS_SYNC_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module uart_timestamp_gen #(
   parameter int CLK_FREQ_HZ = 40_000_000,
   parameter int SUB_MS_DIV  = 10
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   uart_timestamp_gen_if.slave ts
);

   localparam int PRESC_DIV = CLK_FREQ_HZ / (1000 * SUB_MS_DIV);
   localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PW-1:0] c_presc_last = PW'(PRESC_DIV - 1);
   localparam logic [3:0]    c_acq_last   = 4'(SUB_MS_DIV - 1);
   localparam logic [11:0]   c_ms_last    = 12'd999;

   logic [PW-1:0] r_presc;
   logic [3:0]    r_acq;
   logic [11:0]   r_ms;
   logic [31:0]   r_sec;
   logic          r_tick_acq, r_tick_ms, r_tick_sec;
   logic [47:0]   r_snap;
   logic          r_snap_valid;

   logic [PW-1:0] w_presc_nxt;
   logic [3:0]    w_acq_nxt;
   logic [11:0]   w_ms_nxt;
   logic [31:0]   w_sec_nxt;
   logic          w_tick_acq, w_tick_ms, w_tick_sec;

`ifdef PPS_SYNC_EN
   logic          r_pps_s1, r_pps_s2, r_pps_d;
   logic [10:0]   r_pps_ms;
   logic          r_pps_lost;
   logic          w_pps_edge;

   assign w_pps_edge     = r_pps_s2 & ~r_pps_d;
   assign ts.p_PpsLost_o = r_pps_lost;
`endif

   // Load has top priority, then the PPS re-alignment, then normal counting.
   always_comb begin
      w_presc_nxt = r_presc;
      w_acq_nxt   = r_acq;
      w_ms_nxt    = r_ms;
      w_sec_nxt   = r_sec;
      w_tick_acq  = 1'b0;
      w_tick_ms   = 1'b0;
      w_tick_sec  = 1'b0;
      if (ts.p_SecLoad_i) begin
         w_presc_nxt = '0;
         w_acq_nxt   = '0;
         w_ms_nxt    = '0;
         w_sec_nxt   = ts.SecLoadVal_i;
      end
`ifdef PPS_SYNC_EN
      else if (w_pps_edge) begin
         w_presc_nxt = '0;
         w_acq_nxt   = '0;
         w_ms_nxt    = '0;
         if (r_ms >= 12'd500) begin
            w_sec_nxt  = r_sec + 32'd1;
            w_tick_sec = 1'b1;
         end
      end
`endif
      else if (ts.p_Enable_i) begin
         if (r_presc == c_presc_last) begin
            w_presc_nxt = '0;
            w_tick_acq  = 1'b1;
            if (r_acq == c_acq_last) begin
               w_acq_nxt = '0;
               w_tick_ms = 1'b1;
               if (r_ms == c_ms_last) begin
                  w_ms_nxt   = '0;
                  w_sec_nxt  = r_sec + 32'd1;
                  w_tick_sec = 1'b1;
               end else begin
                  w_ms_nxt = r_ms + 12'd1;
               end
            end else begin
               w_acq_nxt = r_acq + 4'd1;
            end
         end else begin
            w_presc_nxt = r_presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc      <= '0;
         r_acq        <= '0;
         r_ms         <= '0;
         r_sec        <= '0;
         r_tick_acq   <= 1'b0;
         r_tick_ms    <= 1'b0;
         r_tick_sec   <= 1'b0;
         r_snap       <= '0;
         r_snap_valid <= 1'b0;
      end else begin
         r_presc      <= w_presc_nxt;
         r_acq        <= w_acq_nxt;
         r_ms         <= w_ms_nxt;
         r_sec        <= w_sec_nxt;
         r_tick_acq   <= w_tick_acq;
         r_tick_ms    <= w_tick_ms;
         r_tick_sec   <= w_tick_sec;
         r_snap_valid <= ts.p_Snapshot_i;
         // Captures the registered stamps, i.e. the pre-update values.
         if (ts.p_Snapshot_i)
            r_snap <= {r_sec, r_ms, r_acq};
      end
   end

`ifdef PPS_SYNC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pps_s1   <= 1'b0;
         r_pps_s2   <= 1'b0;
         r_pps_d    <= 1'b0;
         r_pps_ms   <= '0;
         r_pps_lost <= 1'b0;
      end else begin
         r_pps_s1 <= ts.pps_i;
         r_pps_s2 <= r_pps_s1;
         r_pps_d  <= r_pps_s2;
         if (w_pps_edge && !ts.p_SecLoad_i) begin
            r_pps_ms   <= '0;
            r_pps_lost <= 1'b0;
         end else if (w_tick_ms && !r_pps_lost) begin
            if (r_pps_ms == 11'd1499)
               r_pps_lost <= 1'b1;
            r_pps_ms <= r_pps_ms + 11'd1;
         end
      end
   end
`endif

   assign ts.acqurate_stamp_o    = r_acq;
   assign ts.millisecond_stamp_o = r_ms;
   assign ts.second_stamp_o      = r_sec;
   assign ts.p_TickAcq_o         = r_tick_acq;
   assign ts.p_TickMs_o          = r_tick_ms;
   assign ts.p_TickSec_o         = r_tick_sec;
   assign ts.SnapStamp_o         = r_snap;
   assign ts.p_SnapValid_o       = r_snap_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_timestamp_gen.sv
// ============================================================================
//  tb_uart_timestamp_gen
//  Bench for uart_timestamp_gen: time is modelled as an elapsed-clock count.
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_timestamp_gen;

   localparam int  CLK_HZ  = 100_000;
   localparam int  SUB     = 10;
   localparam int  P       = CLK_HZ / (1000 * SUB);
   localparam int  CLK2_HZ = 20_000;
   localparam int  P2      = CLK2_HZ / (1000 * SUB);
   localparam longint PL   = longint'(P);
   localparam longint SL   = longint'(SUB);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_timestamp_gen_if ifc ();
   uart_timestamp_gen_if ifc2 ();

   uart_timestamp_gen #(.CLK_FREQ_HZ(CLK_HZ), .SUB_MS_DIV(SUB)) dut (
      .clk(clk), .rst_n(rst_n), .ts(ifc.slave));

   uart_timestamp_gen #(.CLK_FREQ_HZ(CLK2_HZ), .SUB_MS_DIV(SUB)) dut2 (
      .clk(clk), .rst_n(rst_n), .ts(ifc2.slave));

   int n_checks = 0;
   int n_pass   = 0;

   // Reference: enabled clocks since the last load plus the loaded second.
   longint unsigned m_t    = 0;
   logic [31:0]     m_base = '0;
   logic            m_ta = 1'b0, m_tm = 1'b0, m_ts = 1'b0, m_sv = 1'b0;
   logic [47:0]     m_snap = '0;

   function automatic logic [3:0]  e_acq();  return 4'((m_t / PL) % SL); endfunction
   function automatic logic [11:0] e_ms();   return 12'((m_t / (PL * SL)) % 1000); endfunction
   function automatic logic [31:0] e_sec();  return m_base + 32'(m_t / (PL * SL * 1000)); endfunction
   function automatic logic [47:0] e_stamp(); return {e_sec(), e_ms(), e_acq()}; endfunction
   function automatic logic [99:0] e_all();
      return {e_stamp(), m_ta, m_tm, m_ts, m_sv, m_snap};
   endfunction
   function automatic logic [99:0] o_all();
      return {ifc.second_stamp_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o,
              ifc.p_TickAcq_o, ifc.p_TickMs_o, ifc.p_TickSec_o, ifc.p_SnapValid_o,
              ifc.SnapStamp_o};
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then settle.
   task automatic step();
      logic [47:0] pre;
      @(posedge clk);
      pre  = e_stamp();
      m_sv = ifc.p_Snapshot_i;
      if (ifc.p_Snapshot_i) m_snap = pre;
      m_ta = 1'b0; m_tm = 1'b0; m_ts = 1'b0;
      if (ifc.p_SecLoad_i) begin
         m_base = ifc.SecLoadVal_i;
         m_t    = 0;
      end else if (ifc.p_Enable_i) begin
         m_t++;
         m_ta = (m_t % PL == 0);
         m_tm = (m_t % (PL * SL) == 0);
         m_ts = (m_t % (PL * SL * 1000) == 0);
      end
      #1;
   endtask

   task automatic test_reset();
      ifc.p_Enable_i = 1'b1; ifc.p_SecLoad_i = 1'b0; ifc.SecLoadVal_i = $urandom;
      ifc.p_Snapshot_i = 1'b1;
      ifc2.p_Enable_i = 1'b0; ifc2.p_SecLoad_i = 1'b0; ifc2.SecLoadVal_i = '0;
      ifc2.p_Snapshot_i = 1'b0;
`ifdef PPS_SYNC_EN
      ifc.pps_i = 1'b0; ifc2.pps_i = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (o_all() !== 100'd0)
         $display("FAIL reset_outputs: got %h want 0", o_all());
      else n_pass++;
      ifc.p_Snapshot_i = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_first_tick();
      for (int i = 1; i <= 100; i++) begin
         step();
         n_checks++;
         if (ifc.p_TickAcq_o !== (i % P == 0))
            $display("FAIL first_tick_acq clk%0d: got %0b want %0b", i, ifc.p_TickAcq_o, (i % P == 0));
         else n_pass++;
         if (i == P) begin
            n_checks++;
            if (ifc.acqurate_stamp_o !== 4'd1)
               $display("FAIL first_tick_acqval: got %0d want 1", ifc.acqurate_stamp_o);
            else n_pass++;
         end
      end
      n_checks++;
      if ({ifc.p_TickMs_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o} !== {1'b1, 12'd1, 4'd0})
         $display("FAIL first_ms_tick: got tick=%0b ms=%0d acq=%0d want 1/1/0",
                  ifc.p_TickMs_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o);
      else n_pass++;
   endtask

   task automatic test_load();
      int n;
      for (int k = 0; k < P && (m_t % PL) != PL - 1; k++) step();
      ifc.p_SecLoad_i = 1'b1; ifc.SecLoadVal_i = 32'h1234_5678;
      step();
      ifc.p_SecLoad_i = 1'b0;
      n_checks++;
      if ({ifc.second_stamp_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o,
           ifc.p_TickAcq_o, ifc.p_TickMs_o, ifc.p_TickSec_o} !== {32'h1234_5678, 12'd0, 4'd0, 3'b000})
         $display("FAIL load_on_tick: got sec=%h ms=%0d acq=%0d ticks=%b want 12345678/0/0/000",
                  ifc.second_stamp_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o,
                  {ifc.p_TickAcq_o, ifc.p_TickMs_o, ifc.p_TickSec_o});
      else n_pass++;
      n = 0;
      do begin step(); n++; end while (!ifc.p_TickAcq_o && n < 4 * P);
      n_checks++;
      if (n != P) $display("FAIL load_presc_clear: got %0d clocks want %0d", n, P);
      else n_pass++;
   endtask

   task automatic test_snapshot_carry();
      ifc.p_SecLoad_i = 1'b1; ifc.SecLoadVal_i = 32'h0000_0ABC;
      step();
      ifc.p_SecLoad_i = 1'b0;
      repeat ((41 * SUB + 9) * P + (P - 1)) step();
      n_checks++;
      if ({ifc.millisecond_stamp_o, ifc.acqurate_stamp_o} !== {12'd41, 4'd9})
         $display("FAIL snap_setup: got ms=%0d acq=%0d want 41/9", ifc.millisecond_stamp_o, ifc.acqurate_stamp_o);
      else n_pass++;
      ifc.p_Snapshot_i = 1'b1;
      step();
      ifc.p_Snapshot_i = 1'b0;
      n_checks++;
      if ({ifc.SnapStamp_o, ifc.p_SnapValid_o} !== {32'h0000_0ABC, 12'd41, 4'd9, 1'b1})
         $display("FAIL snap_carry: got snap=%h valid=%0b want 00000abc0299 valid=1", ifc.SnapStamp_o, ifc.p_SnapValid_o);
      else n_pass++;
      n_checks++;
      if ({ifc.millisecond_stamp_o, ifc.acqurate_stamp_o, ifc.p_TickMs_o} !== {12'd42, 4'd0, 1'b1})
         $display("FAIL snap_carry_stamp: got ms=%0d acq=%0d tms=%0b want 42/0/1",
                  ifc.millisecond_stamp_o, ifc.acqurate_stamp_o, ifc.p_TickMs_o);
      else n_pass++;
      step();
      n_checks++;
      if ({ifc.SnapStamp_o, ifc.p_SnapValid_o} !== {32'h0000_0ABC, 12'd41, 4'd9, 1'b0})
         $display("FAIL snap_hold: got snap=%h valid=%0b want 00000abc0299 valid=0", ifc.SnapStamp_o, ifc.p_SnapValid_o);
      else n_pass++;
   endtask

   task automatic test_enable_freeze();
      logic [47:0] frozen;
      int remaining, n;
      repeat (3) step();
      remaining = P - int'(m_t % PL);
      frozen    = e_stamp();
      ifc.p_Enable_i = 1'b0;
      for (int i = 0; i < 37; i++) begin
         step();
         n_checks++;
         if ({ifc.second_stamp_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o,
              ifc.p_TickAcq_o, ifc.p_TickMs_o, ifc.p_TickSec_o} !== {frozen, 3'b000})
            $display("FAIL freeze_hold cyc%0d: got %h ticks=%b want %h ticks=000", i,
                     {ifc.second_stamp_o, ifc.millisecond_stamp_o, ifc.acqurate_stamp_o},
                     {ifc.p_TickAcq_o, ifc.p_TickMs_o, ifc.p_TickSec_o}, frozen);
         else n_pass++;
      end
      ifc.p_Enable_i = 1'b1;
      n = 0;
      do begin step(); n++; end while (!ifc.p_TickAcq_o && n < 4 * P);
      n_checks++;
      if (n + 37 != remaining + 37)
         $display("FAIL freeze_delay: got next tick %0d clocks after freeze, want %0d", n + 37, remaining + 37);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      ifc.p_Snapshot_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({ifc.p_SnapValid_o, ifc.SnapStamp_o} !== {1'b1, m_snap})
            $display("FAIL b2b_snap%0d: got v=%0b %h want v=1 %h", i, ifc.p_SnapValid_o, ifc.SnapStamp_o, m_snap);
         else n_pass++;
      end
      ifc.p_Snapshot_i = 1'b0;
      step();
   endtask

   task automatic test_wrap();
      int sec_ticks;
      ifc2.p_Enable_i = 1'b1; ifc2.p_SecLoad_i = 1'b1; ifc2.SecLoadVal_i = 32'hFFFF_FFFF;
      step();
      ifc2.p_SecLoad_i = 1'b0;
      sec_ticks = 0;
      for (int i = 0; i < P2 * SUB * 1000 - 1; i++) begin
         step();
         if (ifc2.p_TickSec_o) sec_ticks++;
      end
      n_checks++;
      if ({ifc2.second_stamp_o, ifc2.millisecond_stamp_o, ifc2.acqurate_stamp_o} !== {32'hFFFF_FFFF, 12'd999, 4'd9}
          || sec_ticks != 0)
         $display("FAIL wrap_pre: got sec=%h ms=%0d acq=%0d secticks=%0d want ffffffff/999/9/0",
                  ifc2.second_stamp_o, ifc2.millisecond_stamp_o, ifc2.acqurate_stamp_o, sec_ticks);
      else n_pass++;
      step();
      n_checks++;
      if ({ifc2.second_stamp_o, ifc2.millisecond_stamp_o, ifc2.acqurate_stamp_o,
           ifc2.p_TickAcq_o, ifc2.p_TickMs_o, ifc2.p_TickSec_o} !== {48'd0, 3'b111})
         $display("FAIL wrap_all: got sec=%h ms=%0d acq=%0d ticks=%b want 0/0/0/111",
                  ifc2.second_stamp_o, ifc2.millisecond_stamp_o, ifc2.acqurate_stamp_o,
                  {ifc2.p_TickAcq_o, ifc2.p_TickMs_o, ifc2.p_TickSec_o});
      else n_pass++;
      ifc2.p_Enable_i = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         ifc.p_Enable_i   = ($urandom_range(0, 9) != 0);
         ifc.p_SecLoad_i  = ($urandom_range(0, 199) == 0);
         ifc.SecLoadVal_i = $urandom;
         ifc.p_Snapshot_i = ($urandom_range(0, 7) == 0);
         step();
         n_checks++;
         if (o_all() !== e_all())
            $display("FAIL random cyc%0d: got %h want %h", i, o_all(), e_all());
         else n_pass++;
      end
      ifc.p_SecLoad_i = 1'b0; ifc.p_Snapshot_i = 1'b0; ifc.p_Enable_i = 1'b1;
   endtask

`ifdef PPS_SYNC_EN
   task automatic test_pps();
      ifc2.p_Enable_i = 1'b1; ifc2.p_SecLoad_i = 1'b1; ifc2.SecLoadVal_i = 32'd5;
      step();
      ifc2.p_SecLoad_i = 1'b0;
      repeat (700 * SUB * P2) step();
      ifc2.pps_i = 1'b1;
      repeat (2) step();
      n_checks++;
      if (ifc2.second_stamp_o !== 32'd5)
         $display("FAIL pps_early: got sec=%0d want 5", ifc2.second_stamp_o);
      else n_pass++;
      step();
      n_checks++;
      if ({ifc2.second_stamp_o, ifc2.millisecond_stamp_o, ifc2.acqurate_stamp_o, ifc2.p_TickSec_o}
          !== {32'd6, 12'd0, 4'd0, 1'b1})
         $display("FAIL pps_align: got sec=%0d ms=%0d acq=%0d tsec=%0b want 6/0/0/1",
                  ifc2.second_stamp_o, ifc2.millisecond_stamp_o, ifc2.acqurate_stamp_o, ifc2.p_TickSec_o);
      else n_pass++;
      ifc2.pps_i = 1'b0;
      ifc2.p_Enable_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_first_tick();
      test_load();
      test_snapshot_carry();
      test_enable_freeze();
      test_back_to_back();
      test_wrap();
      test_random();
`ifdef PPS_SYNC_EN
      test_pps();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
